// File: rtl/uart_rx_frame.sv
// ============================================================================
// Module   : uart_rx_frame
// Brief    : Parametrised UART receiver with majority-vote sampling, error
//            flags and a valid/ready output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    input  logic                  ready,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int c_T    = CLK_FREQ / BAUD_RATE;
    localparam int c_HALF = c_T / 2;
    localparam int c_CW   = $clog2(c_T);

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_T - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_S0       = c_CW'(c_HALF - 1);
    localparam logic [c_CW-1:0] c_S1       = c_CW'(c_HALF);
    localparam logic [c_CW-1:0] c_S2       = c_CW'(c_HALF + 1);
    localparam logic [3:0]      c_DLAST    = 4'(DATA_WIDTH - 1);
    localparam logic [3:0]      c_SLAST    = 4'(STOP_BITS - 1);
    localparam logic [3:0]      c_IDX_ONE  = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_prev;
    logic [c_CW-1:0]       r_cnt;
    logic [3:0]            r_idx;
    logic                  r_s0;
    logic                  r_s1;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_perr_pend;
    logic                  r_ferr_pend;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_parity_err;
    logic                  r_frame_err;
    logic                  r_overrun;
    logic                  r_busy;

    logic w_maj;
    logic w_decide;
    logic w_wrap;
    logic w_start;
    logic w_par_exp;
    logic w_done;
    logic w_ferr_final;

    // Third sample is taken live from the synchroniser at the decision cycle.
    assign w_maj        = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
    assign w_decide     = (r_cnt == c_S2);
    assign w_wrap       = (r_cnt == c_CNT_LAST);
    assign w_start      = r_prev & ~r_sync2;
    assign w_par_exp    = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
    assign w_done       = (r_state == ST_STOP) && w_decide && (r_idx == c_SLAST);
    assign w_ferr_final = r_ferr_pend | ~w_maj;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_s0         <= 1'b1;
            r_s1         <= 1'b1;
            r_shift      <= '0;
            r_perr_pend  <= 1'b0;
            r_ferr_pend  <= 1'b0;
            r_busy       <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (r_state != ST_IDLE) begin
                r_cnt <= w_wrap ? '0 : r_cnt + c_CNT_ONE;
                if (r_cnt == c_S0) r_s0 <= r_sync2;
                if (r_cnt == c_S1) r_s1 <= r_sync2;
            end

            case (r_state)
                ST_IDLE: begin
                    // Detection cycle counts as cnt=0 of the start bit.
                    if (w_start) begin
                        r_state     <= ST_START;
                        r_busy      <= 1'b1;
                        r_cnt       <= c_CNT_ONE;
                        r_idx       <= '0;
                        r_perr_pend <= 1'b0;
                        r_ferr_pend <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_decide && w_maj) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (w_wrap) begin
                        r_state <= ST_DATA;
                        r_idx   <= '0;
                    end
                end
                ST_DATA: begin
                    if (w_decide) r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                    if (w_wrap) begin
                        if (r_idx == c_DLAST) begin
                            r_idx   <= '0;
                            r_state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_idx <= r_idx + c_IDX_ONE;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_decide && (w_maj != w_par_exp)) r_perr_pend <= 1'b1;
                    if (w_wrap) r_state <= ST_STOP;
                end
                ST_STOP: begin
                    if (w_decide) begin
                        if (!w_maj) r_ferr_pend <= 1'b1;
                        // Leave at the last decision so back-to-back frames line up.
                        if (r_idx == c_SLAST) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_cnt   <= '0;
                        end
                    end
                    if (w_wrap) r_idx <= r_idx + c_IDX_ONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_done) begin
                if (!r_valid || ready) begin
                    r_data       <= r_shift;
                    r_parity_err <= r_perr_pend;
                    r_frame_err  <= w_ferr_final;
                    r_valid      <= 1'b1;
                    if (r_valid) r_overrun <= 1'b0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver, successor to the fixed 8N1 receiver. It adds the following over that block:
- configurable data width, parity and stop-bit count;
- input synchronisation and 3-sample majority voting per bit;
- false-start rejection and parity/framing/overrun error reporting;
- a valid/ready output register.

It sits between the board RX pin and the RX FIFO feeding the AXI/DDR write path.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9)
- CLK_FREQ, 100_000_000, clk frequency in Hz
- BAUD_RATE, 115200, line rate; T = CLK_FREQ/BAUD_RATE clocks per bit, T >= 16 required
- PARITY, 0, 0 none / 1 odd / 2 even
- STOP_BITS, 1, 1 or 2
- clk  input  1  single clock; all logic on posedge
- rst  input  1  reset, synchronous and active-high
- rx  input  1  asynchronous serial line, idle high
- data  output  DATA_WIDTH  received word, LSB first on the line
- valid  output  1  data/flags hold a frame
- ready  input  1  consumer accepts the word when valid & ready
- parity_err  output  1  parity mismatch for the word in data (0 when PARITY=0)
- frame_err  output  1  any stop bit sampled low for the word in data
- overrun  output  1  sticky; a frame was dropped because valid was still held
- busy  output  1  receiver FSM not in IDLE

## Operation
- rx passes through a 2-flop synchroniser; both flops reset to 1.
- Start detection uses the synchronised value: previous 1, current 0.
- Bit timer cnt runs 0..T-1 and wraps at each bit boundary. The detection cycle is cnt=0 of the start bit.
- Each bit is sampled at cnt = T/2-1, T/2 and T/2+1 (T/2 truncated). The bit value is the 2-of-3 majority, decided at cnt = T/2+1.
- FSM states: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
- START: if the majority is 1, the start is false. Return to IDLE at the decision cycle; no output, no flags.
- DATA: DATA_WIDTH bits, shifted in LSB first. A bit index counter advances at each bit boundary.
- PARITY: the received parity bit is compared with the XOR of the data bits (even) or its inverse (odd). A mismatch sets the pending parity error.
- STOP: STOP_BITS bits. Any stop bit with majority 0 sets the pending frame error.
- At the decision of the last stop bit, the FSM goes to IDLE in the same cycle. The remaining half stop bit is not waited out, so back-to-back frames are received.
- Output register handling at frame completion:
  - valid=0: load data/parity_err/frame_err, valid=1 next cycle.
  - valid=1 and ready=1 in the same cycle: old word is consumed, new word is loaded, valid stays 1, no overrun.
  - valid=1 and ready=0: new frame is discarded, old word and its flags are kept, overrun=1.
- Handshake: valid & ready in a cycle without completion clears valid next cycle. data and flags are held until then.
- overrun clears on the next accepted handshake.
- Frames with errors, including break (all-zero, frame_err=1), are delivered normally with their flags.

## Timing
- Reset values: data=0, valid=0, parity_err=0, frame_err=0, overrun=0, busy=0; FSM IDLE; cnt=0.
- Reset mid-frame: the frame is abandoned with no output. Synchroniser at 1, so no spurious start after release.
- Latency: N = 1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS bits. valid rises at detection cycle + (N-1)*T + T/2 + 2.
- busy is 1 from the cycle after detection until the last-stop-bit decision cycle inclusive.
- ready has no combinational path to any output; all outputs are registered.
- Start detection in IDLE is enabled on the cycle after returning from STOP.
- Glitch tolerance: a single-cycle inversion within any sample window is rejected. A low pulse shorter than T/2-1 cycles is rejected as a false start.

## Test plan
- T=16 (CLK_FREQ=1_600_000, BAUD_RATE=100_000), 8N1, send 0xA5, ready=1 -> data=0xA5, valid for 1 cycle, flags 0, valid rises at detection+9*16+10.
- PARITY=2, send 0x07 with parity bit 0 -> data=0x07, parity_err=1; resend with parity bit 1 -> parity_err=0.
- STOP_BITS=2, second stop bit driven low -> frame_err=1, data correct; all-zero break frame -> data=0x00, frame_err=1.
- rx low for 6 cycles then high -> no valid, busy falls by cnt=9. A 1-cycle glitch mid data bit 3 of 0x55 -> data=0x55.
- ready=0, send 0x11 then 0x22 back-to-back -> data=0x11 held, overrun=1. Pulse ready -> valid=0, overrun=0. Then 0x33 with ready=1 -> data=0x33.
- Assert rst for 1 cycle during data bit 4 -> all outputs 0, no valid for that frame. Next frame 0x3C is received correctly.
